// File: rtl/muldiv_seq_pkg.sv
// Shared constants and state type for the M-extension multiply/divide sequencer.
package muldiv_seq_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request, core and result signals between the EXE stage and the muldiv sequencer.
interface muldiv_seq_if;
    logic        req_valid;
    logic [2:0]  req_f3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_f3;
    logic [31:0] mul_result;
    logic [31:0] div_result;

    modport slave (
        input  req_valid, req_f3, req_rs1, req_rs2, flush, mul_result, div_result,
        output stall, done, result, op_a, op_b, op_f3
    );

    modport master (
        output req_valid, req_f3, req_rs1, req_rs2, flush, mul_result, div_result,
        input  stall, done, result, op_a, op_b, op_f3
    );
endinterface

// File: rtl/muldiv_seq_special.sv
// Detects divide-by-zero and signed-overflow divides and supplies their architectural result.
module muldiv_special
    import muldiv_seq_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  f3,
    output logic        is_special,
    output logic [31:0] special_result
);

    // f3[2] selects divide class, f3[1] selects remainder, f3[0] selects unsigned
    always_comb begin
        is_special     = 1'b0;
        special_result = 32'h0;
        if (f3[2]) begin
            if (rs2 == 32'h0) begin
                is_special     = 1'b1;
                special_result = f3[1] ? rs1 : DIV_BY_ZERO_Q;
            end else if (!f3[0] && rs1 == INT_MIN && rs2 == 32'hFFFF_FFFF) begin
                is_special     = 1'b1;
                special_result = f3[1] ? 32'h0 : INT_MIN;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequences one MUL/DIV request through the external cores, counting fixed latency and stalling EXE.
//
// state       | meaning
// ST_IDLE     | waiting for a request; latches operands when one arrives
// ST_MUL_WAIT | counting down multiplier latency
// ST_DIV_WAIT | counting down divider latency
// ST_DONE     | result valid, done pulses, EXE advances
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 15
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_seq_if.slave   bus
);

    localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

    state_t      state;
    logic [7:0]  count;
    logic        is_special;
    logic [31:0] special_result;

    muldiv_special u_special (
        .rs1            (bus.req_rs1),
        .rs2            (bus.req_rs2),
        .f3             (bus.req_f3),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign bus.stall = bus.req_valid && (state != ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= 8'h0;
            bus.op_a   <= 32'h0;
            bus.op_b   <= 32'h0;
            bus.op_f3  <= 3'b000;
            bus.result <= 32'h0;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        bus.op_a  <= bus.req_rs1;
                        bus.op_b  <= bus.req_rs2;
                        bus.op_f3 <= bus.req_f3;
                        if (!bus.req_f3[2]) begin
                            count <= MUL_CNT;
                            state <= ST_MUL_WAIT;
                        end else if (is_special) begin
                            bus.result <= special_result;
                            bus.done   <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            count <= DIV_CNT;
                            state <= ST_DIV_WAIT;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (count != 8'h0) begin
                        count <= count - 8'h1;
                    end else begin
                        bus.result <= bus.mul_result;
                        bus.done   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DIV_WAIT: begin
                    if (bus.flush) begin
                        state <= ST_IDLE;
                    end else if (count != 8'h0) begin
                        count <= count - 8'h1;
                    end else begin
                        bus.result <= bus.div_result;
                        bus.done   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with latency-accurate core stubs and an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_exp = 32'h0;

    muldiv_seq_if bus ();

    muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RISC-V M-extension semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_fn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        p  = 64'h0;
        case (f3)
            F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV:    begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb); return p[31:0];
            end
            F3_DIVU:   begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            F3_REM:    begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default:   begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Core stubs: output is only correct once the latched operands have been stable for the core latency
    int         scnt = 0;
    logic [66:0] prev_ops = 67'h0;
    always @(negedge clk) begin
        if ({bus.op_f3, bus.op_a, bus.op_b} == prev_ops) scnt <= (scnt < 1000) ? scnt + 1 : scnt;
        else scnt <= 1;
        prev_ops <= {bus.op_f3, bus.op_a, bus.op_b};
    end

    assign bus.mul_result = (scnt >= MUL_LAT && !bus.op_f3[2]) ? ref_fn(bus.op_f3, bus.op_a, bus.op_b) : 32'hDEAD_BEEF;
    assign bus.div_result = (scnt >= DIV_LAT &&  bus.op_f3[2] && bus.op_b != 32'h0)
                            ? ref_fn(bus.op_f3, bus.op_a, bus.op_b) : 32'hBAD0_D1F0;

    function automatic bit is_special_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Caller is #1 after a rising edge with the DUT in IDLE; returns the same way.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input bit hold, input string name);
        int          lat;
        logic [31:0] exp;
        exp = ref_fn(f3, a, b);
        lat = is_special_op(f3, a, b) ? 1 : (f3[2] ? DIV_LAT + 1 : MUL_LAT + 1);
        bus.req_valid = 1'b1;
        bus.req_f3    = f3;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s wait cycle %0d: stall=%b done=%b, want stall=1 done=0", name, c, bus.stall, bus.done);
            end
            if (c > 0) begin
                checks++;
                if (bus.op_a !== a || bus.op_b !== b || bus.op_f3 !== f3) begin
                    errors++;
                    $display("FAIL %s operand hold cycle %0d: op_a=%h op_b=%h op_f3=%b, want %h %h %b",
                             name, c, bus.op_a, bus.op_b, bus.op_f3, a, b, f3);
                end
            end
            @(posedge clk); #1;
            bus.req_rs1 = $urandom;
            bus.req_rs2 = $urandom;
            bus.req_f3  = 3'($urandom);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.result !== exp || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL %s completion: done=%b result=%h stall=%b, want done=1 result=%h stall=0",
                     name, bus.done, bus.result, bus.stall, exp);
        end
        last_exp = exp;
        @(posedge clk); #1;
        if (!hold) begin
            bus.req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== exp) begin
                errors++;
                $display("FAIL %s after done: done=%b stall=%b result=%h, want 0 0 %h",
                         name, bus.done, bus.stall, bus.result, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        bus.req_f3 = 3'b000; bus.req_rs1 = 32'h0; bus.req_rs2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'h0 || bus.op_a !== 32'h0 || bus.op_b !== 32'h0 ||
            bus.op_f3 !== 3'b000 || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: done=%b result=%h op_a=%h op_b=%h op_f3=%b stall=%b, want all zero",
                     bus.done, bus.result, bus.op_a, bus.op_b, bus.op_f3, bus.stall);
        end
        bus.req_valid = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL reset stall: stall=%b, want 1 with req_valid=1", bus.stall);
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_exp = 32'h0;
    endtask

    task automatic test_mul;
        issue_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7x-3");
        issue_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh");
        issue_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        issue_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu");
    endtask

    task automatic test_div;
        issue_op(F3_DIVU, 32'd100, 32'd7, 1'b0, "divu_100/7");
        issue_op(F3_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, "div_neg");
        issue_op(F3_REM, 32'hFFFF_FF9C, 32'd7, 1'b0, "rem_neg");
    endtask

    task automatic test_special;
        issue_op(F3_DIV,  32'd5, 32'd0, 1'b0, "div_by_zero");
        issue_op(F3_REMU, 32'd5, 32'd0, 1'b0, "remu_by_zero");
        issue_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        issue_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_overflow");
        issue_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_no_overflow");
    endtask

    task automatic test_flush;
        // flush in DIV_WAIT drops the operation
        bus.req_valid = 1'b1; bus.req_f3 = F3_DIV; bus.req_rs1 = 32'd1000; bus.req_rs2 = 32'd7;
        repeat (3) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.result !== last_exp || bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait: done=%b result=%h stall=%b, want 0 %h 0", bus.done, bus.result, bus.stall, last_exp);
        end
        @(posedge clk); #1;
        issue_op(F3_MUL, 32'd12, 32'd11, 1'b0, "mul_after_flush");
        // flush together with a request in IDLE ignores it
        bus.req_valid = 1'b1; bus.flush = 1'b1; bus.req_f3 = F3_DIVU; bus.req_rs1 = 32'd9; bus.req_rs2 = 32'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.result !== last_exp) begin
            errors++;
            $display("FAIL flush_idle: done=%b result=%h, want 0 %h", bus.done, bus.result, last_exp);
        end
        @(posedge clk); #1;
        issue_op(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "mul_after_idle_flush");
    endtask

    task automatic test_rst_mid;
        bus.req_valid = 1'b1; bus.req_f3 = F3_MUL; bus.req_rs1 = 32'd3; bus.req_rs2 = 32'd4;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'h0 || bus.op_a !== 32'h0 || bus.op_b !== 32'h0 ||
            bus.op_f3 !== 3'b000 || bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: done=%b result=%h op_a=%h op_b=%h op_f3=%b stall=%b, want 0 0 0 0 0 1",
                     bus.done, bus.result, bus.op_a, bus.op_b, bus.op_f3, bus.stall);
        end
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid stall: stall=%b, want 0", bus.stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        last_exp = 32'h0;
        issue_op(F3_MUL, 32'd3, 32'd4, 1'b0, "mul_after_rst");
    endtask

    task automatic test_back_to_back;
        issue_op(F3_MUL, 32'd6, 32'd9, 1'b1, "b2b_mul");
        issue_op(F3_DIVU, 32'd81, 32'd4, 1'b1, "b2b_divu");
        issue_op(F3_REMU, 32'd81, 32'd0, 1'b1, "b2b_remu0");
        issue_op(F3_MULH, 32'hFFFF_FFF0, 32'd3, 1'b0, "b2b_mulh");
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          r;
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 7);
            if (r == 0) b = 32'h0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 20));
            issue_op(f3, a, b, ($urandom_range(0, 1) == 1), "random");
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Sequencer for the pipelined M-extension multiplier and divider cores in the EXE stage.
- Accepts one MUL/DIV request at a time and holds operands and function code stable toward the cores.
- Counts each core's fixed pipeline latency, captures the result, and generates the EXE stall.
- Resolves RISC-V divide-by-zero and signed-overflow cases locally, without waiting on the divider.
- Replaces start detection by hierarchical reference into the CPU; all request information arrives on ports.

Parameters:
- MUL_LAT, 5, cycles from operands stable at multiplier inputs to a valid mul_result (legal range 1..255).
- DIV_LAT, 15, cycles from operands stable at divider inputs to a valid div_result (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EXE holds a MUL-class instruction (OP opcode, f7 = 0000001).
- req_f3  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1  in  32  operand 1.
- req_rs2  in  32  operand 2.
- flush  in  1  kill the in-flight operation (branch/jump redirect).
- stall  out  1  freeze the pipeline at EXE and earlier.
- done  out  1  one-cycle pulse; result is valid.
- result  out  32  registered result.
- op_a  out  32  latched rs1 to both cores.
- op_b  out  32  latched rs2 to both cores.
- op_f3  out  3  latched funct3 to the core result muxes.
- mul_result  in  32  multiplier core output, already selected by op_f3.
- div_result  in  32  divider core output, already selected by op_f3.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE; count = 0.
  - op_a, op_b, result = 0; op_f3 = 000; done = 0.
  - rst has priority over every other input, including mid-operation.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE. The encoding is internal.
- IDLE, when req_valid=1 and flush=0:
  - Latch req_rs1/req_rs2/req_f3 into op_a/op_b/op_f3.
  - If f3[2]=0: count = MUL_LAT-1, go to MUL_WAIT.
  - If f3[2]=1 and rs2 = 0: go to DONE with a special result.
    - DIV/DIVU: result = 0xFFFFFFFF.
    - REM/REMU: result = rs1.
  - If f3 = 100/110 and rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: go to DONE with a special result.
    - DIV: result = 0x80000000.
    - REM: result = 0.
  - Otherwise: count = DIV_LAT-1, go to DIV_WAIT.
- MUL_WAIT / DIV_WAIT:
  - While count != 0: decrement count.
  - When count = 0: result = mul_result (MUL_WAIT) or div_result (DIV_WAIT), go to DONE.
  - op_a/op_b/op_f3 hold constant for the whole wait.
- DONE:
  - done = 1 for exactly this cycle; stall = 0.
  - Always go to IDLE next cycle.
  - EXE advances on this cycle. If req_valid is still high in the following IDLE cycle, it is a new instruction.
- stall (combinational) = req_valid and not (state == DONE).
  - It rises in the same cycle the request appears; no stall bubble is lost.
- done is registered (asserted when state == DONE). result holds its value until the next capture.
- Latency, with the request first seen in IDLE at cycle T:
  - Multiply: DONE at T+1+MUL_LAT.
  - Normal divide: DONE at T+1+DIV_LAT.
  - Special-case divide: DONE at T+1.
- flush:
  - In IDLE or either WAIT state: next state is IDLE, no done, result unchanged, the request is dropped.
  - In DONE: no effect.
  - flush and req_valid together in IDLE: the request is ignored.
- No overlap: a new request is accepted only in IDLE. The cores are not pipelined-shared.
- req_* changes during a WAIT state are ignored because the latched copies drive the cores.
- Count register is 8 bits.

Decomposition:
- Shared package / defines file holds:
  - the funct3 constants (F3_MUL .. F3_REMU), F7_MULDIV = 7'b0000001;
  - the state encoding localparams;
  - the constants DIV_BY_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- One sub-module is natural: muldiv_special, a combinational detector.
  - Inputs: rs1, rs2, f3.
  - Outputs: is_special and special_result.
- The FSM, counter and registers stay in muldiv_seq.
- The cores stay outside and are instantiated by the ALU.

Test Plan:
- MUL, rs1=7, rs2=-3, MUL_LAT=5, mul_result stubbed to the expected value once op_a is latched -> stall high from T through T+5, done and result=0xFFFFFFEB at T+6, stall low at T+6.
- DIVU, rs1=100, rs2=7, DIV_LAT=15 -> done at T+16, result=14; op_a/op_b stay constant while req_rs1 toggles randomly during the wait.
- DIV by zero: rs1=5, rs2=0 -> done at T+1, result=0xFFFFFFFF. REMU by zero: rs1=5, rs2=0 -> result=5. Divider result is never sampled.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> result=0x80000000 at T+1. REM with the same operands -> result=0.
- flush at T+3 of a DIV -> IDLE at T+4, no done, result keeps its previous value. A new MUL issued at T+5 completes at T+11.
- rst asserted at T+2 of a MUL -> next cycle state=IDLE, done=0, result=0, stall equals req_valid. Back-to-back MUL then DIVU with req_valid held high -> two done pulses, separated by one IDLE cycle.
